// File: rtl/mem_master_ctrl.sv
// Single-outstanding memory access controller: turns a valid/ready request into
// chip-select/strobe sequencing against a memory with a mem_ready busy handshake.
module mem_master_ctrl #(
   parameter int Data_Width = 128,
   parameter int Addr_Width = 25,
   parameter int Timeout    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [Addr_Width-1:0] req_addr,
   input  logic [Data_Width-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [Data_Width-1:0] resp_rdata,
   output logic                  mem_cs,
   output logic                  mem_oe,
   output logic                  mem_we,
   output logic [Addr_Width-1:0] mem_addr,
   inout  wire  [Data_Width-1:0] mem_data,
   input  logic                  mem_ready
);

   localparam int Cnt_Width = $clog2(Timeout) + 1;

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      WR_BUSY,
      RD_ISSUE,
      RD_BUSY,
      RESP
   } state_t;

   state_t                state_reg;
   logic [Cnt_Width-1:0]  wait_cnt_reg;
   logic [Addr_Width-1:0] addr_reg;
   logic [Data_Width-1:0] wdata_reg;
   logic [Data_Width-1:0] rdata_reg;
   logic                  write_reg;
   logic                  cs_reg;
   logic                  oe_reg;
   logic                  we_reg;
   logic                  resp_valid_reg;
   logic                  resp_err_reg;

   logic                  in_access;
   logic                  busy_done;
   logic                  timed_out;
   logic                  go_resp;

   assign in_access = (state_reg == WR_ISSUE) || (state_reg == WR_BUSY) ||
                      (state_reg == RD_ISSUE) || (state_reg == RD_BUSY);
   assign busy_done = ((state_reg == WR_BUSY) || (state_reg == RD_BUSY)) && mem_ready;
   assign timed_out = in_access && (wait_cnt_reg == Cnt_Width'(Timeout - 1));
   assign go_resp   = timed_out || busy_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         wait_cnt_reg   <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         rdata_reg      <= '0;
         write_reg      <= 1'b0;
         cs_reg         <= 1'b0;
         oe_reg         <= 1'b0;
         we_reg         <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
      end else if (go_resp) begin
         // A timeout wins over a simultaneous normal completion.
         state_reg      <= RESP;
         wait_cnt_reg   <= '0;
         cs_reg         <= 1'b0;
         oe_reg         <= 1'b0;
         we_reg         <= 1'b0;
         resp_valid_reg <= 1'b1;
         resp_err_reg   <= timed_out;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid && mem_ready) begin
                  addr_reg     <= req_addr;
                  wdata_reg    <= req_wdata;
                  write_reg    <= req_write;
                  cs_reg       <= 1'b1;
                  oe_reg       <= ~req_write;
                  we_reg       <= req_write;
                  wait_cnt_reg <= '0;
                  state_reg    <= req_write ? WR_ISSUE : RD_ISSUE;
               end
            end
            WR_ISSUE: begin
               if (!mem_ready) begin
                  state_reg    <= WR_BUSY;
                  cs_reg       <= 1'b0;
                  we_reg       <= 1'b0;
                  wait_cnt_reg <= '0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            RD_ISSUE: begin
               // The memory accepted the read: sample the bus once, here only.
               if (!mem_ready) begin
                  rdata_reg    <= mem_data;
                  state_reg    <= RD_BUSY;
                  wait_cnt_reg <= '0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            WR_BUSY, RD_BUSY: begin
               wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            RESP: begin
               state_reg      <= IDLE;
               wait_cnt_reg   <= '0;
               resp_valid_reg <= 1'b0;
               resp_err_reg   <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_reg == IDLE) && mem_ready && !reset;
   assign resp_valid = resp_valid_reg;
   assign resp_err   = resp_err_reg;
   assign resp_rdata = rdata_reg;
   assign mem_cs     = cs_reg;
   assign mem_oe     = oe_reg;
   assign mem_we     = we_reg;
   assign mem_addr   = addr_reg;

   // Only a latched write with the write strobe up may touch the shared bus.
   assign mem_data = (we_reg && write_reg) ? wdata_reg : {Data_Width{1'bz}};

endmodule
